// File: rtl/conv_stream_tx.sv
`default_nettype none
// conv_stream_tx: buffers the free-running convolved pixel stream in a small FIFO
// and re-emits it on a valid/ready stream tagged with sof/eol/eof frame markers.
module conv_stream_tx #(
  parameter int DATA_W     = 8,
  parameter int KERNEL_W   = 3,
  parameter int RESOLUTION = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic [DATA_W-1:0]           pixel_i,
  input  logic                        pixel_valid_i,
  output logic [DATA_W-1:0]           data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        sof_o,
  output logic                        eol_o,
  output logic                        eof_o,
  output logic                        frame_done_o,
  output logic                        overflow_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int OUT_W = RESOLUTION - KERNEL_W + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [CW-1:0]     col;
  logic [CW-1:0]     row;
  logic              overflow;
  state_t            state;

  logic handshake;
  logic pop;
  logic push;
  logic col_last;
  logic row_last;
  logic out_valid_next;

  assign handshake      = out_valid & ready_i;
  // The output register refills whenever it is empty or being consumed.
  assign pop            = (level != '0) & (~out_valid | ready_i);
  assign push           = pixel_valid_i & ((level != FULL) | pop);
  assign col_last       = (col == LAST);
  assign row_last       = (row == LAST);
  assign out_valid_next = pop | (out_valid & ~handshake);

  assign data_o       = out_data;
  assign valid_o      = out_valid;
  assign sof_o        = out_valid & (row == '0) & (col == '0);
  assign eol_o        = out_valid & col_last;
  assign eof_o        = out_valid & col_last & row_last;
  assign frame_done_o = (state == ST_DONE);
  assign overflow_o   = overflow;
  assign fifo_level_o = level;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= pixel_i;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      col       <= '0;
      row       <= '0;
      overflow  <= 1'b0;
      state     <= ST_IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);

      if (pop) out_data <= mem[rd_ptr];
      out_valid <= out_valid_next;

      if (handshake) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      if (pixel_valid_i && !push) overflow <= 1'b1;

      case (state)
        ST_IDLE: if (pop) state <= ST_RUN;
        ST_RUN:  if (handshake && eof_o) state <= ST_DONE;
        ST_DONE: begin
          // A one-line, one-column frame can complete again while still in DONE.
          if (handshake && eof_o) state <= ST_DONE;
          else if (out_valid_next) state <= ST_RUN;
          else state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_tx.sv
`default_nettype none
// tb_conv_stream_tx: directed and randomized checks of conv_stream_tx against a
// queue-based transaction model of the pixel stream.
module tb_conv_stream_tx;

  localparam int DATA_W     = 8;
  localparam int KERNEL_W   = 3;
  localparam int RESOLUTION = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int OUT_W      = RESOLUTION - KERNEL_W + 1;
  localparam int FRAME      = OUT_W * OUT_W;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              arstn = 1'b0;
  logic [DATA_W-1:0] pixel = '0;
  logic              pixel_valid = 1'b0;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] data;
  logic              valid, sof, eol, eof, frame_done, overflow;
  logic [LW-1:0]     fifo_level;

  conv_stream_tx #(
    .DATA_W(DATA_W), .KERNEL_W(KERNEL_W), .RESOLUTION(RESOLUTION), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk), .arstn_i(arstn), .pixel_i(pixel), .pixel_valid_i(pixel_valid),
    .data_o(data), .valid_o(valid), .ready_i(ready), .sof_o(sof), .eol_o(eol),
    .eof_o(eof), .frame_done_o(frame_done), .overflow_o(overflow), .fifo_level_o(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: q holds every accepted pixel still owed downstream; q[0] is on the
  // output when m_valid is set. Tags follow from the count of handshakes.
  logic [DATA_W-1:0] q[$];
  bit m_valid;
  int hs_cnt;
  bit m_ovf;
  bit m_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 0;
    hs_cnt  = 0;
    m_ovf   = 0;
    m_done  = 0;
  endtask

  task automatic check_outputs();
    int k;
    k = hs_cnt % FRAME;
    check_eq("valid", valid, m_valid);
    if (m_valid) begin
      check_eq("data", data, q[0]);
      check_eq("sof", sof, k == 0);
      check_eq("eol", eol, (k % OUT_W) == OUT_W - 1);
      check_eq("eof", eof, k == FRAME - 1);
    end else begin
      check_eq("tags_idle", {sof, eol, eof}, 3'b000);
    end
    check_eq("level", fifo_level, q.size() - int'(m_valid));
    check_eq("overflow", overflow, m_ovf);
    check_eq("frame_done", frame_done, m_done);
  endtask

  // Called one time unit after a rising edge; drives one cycle of inputs.
  task automatic step(input bit pv, input logic [DATA_W-1:0] px, input bit rdy);
    int  fifo_cnt;
    bit  hs, pop, acc;
    pixel_valid = pv;
    pixel       = px;
    ready       = rdy;
    fifo_cnt = q.size() - int'(m_valid);
    hs   = m_valid && rdy;
    pop  = (fifo_cnt > 0) && (!m_valid || rdy);
    acc  = pv && ((fifo_cnt < FIFO_DEPTH) || pop);
    m_done = hs && ((hs_cnt % FRAME) == FRAME - 1);
    if (hs) begin
      void'(q.pop_front());
      hs_cnt++;
    end
    if (pop) m_valid = 1;
    else if (hs) m_valid = 0;
    if (pv && !acc) m_ovf = 1;
    if (acc) q.push_back(px);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic async_reset();
    #2;
    arstn = 1'b0;
    #1;
    check_eq("rst_valid", valid, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_tags", {sof, eol, eof}, 3'b000);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_level", fifo_level, 0);
    model_reset();
    pixel_valid = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    int cnt;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    // Full frame at full rate
    for (int i = 0; i < FRAME; i++) step(1, DATA_W'(i), 1);
    repeat (3) step(0, '0, 1);

    // Backpressure while three pixels arrive
    for (int i = 0; i < 3; i++) step(1, DATA_W'(8'h20 + i), 0);
    check_eq("bp_hold", data, 8'h20);
    check_eq("bp_level", fifo_level, 2);
    repeat (4) step(0, '0, 1);

    // Fill completely, then pop and write in the same cycle
    for (int i = 0; i < 5; i++) step(1, DATA_W'(8'h40 + i), 0);
    check_eq("full_level", fifo_level, FIFO_DEPTH);
    step(1, 8'h45, 1);
    check_eq("fullpop_level", fifo_level, FIFO_DEPTH);
    check_eq("fullpop_ovf", overflow, 0);
    repeat (6) step(0, '0, 1);

    // Overflow: sixth pixel dropped
    for (int i = 0; i < 6; i++) step(1, DATA_W'(8'h30 + i), 0);
    check_eq("ovf_set", overflow, 1);
    check_eq("ovf_head", data, 8'h30);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid) cnt++;
      step(0, '0, 1);
    end
    check_eq("ovf_drain_cnt", cnt, 5);
    check_eq("ovf_sticky", overflow, 1);

    // Asynchronous reset mid-cycle, then a fresh frame start
    async_reset();
    step(1, 8'h11, 1);
    step(0, '0, 0);
    check_eq("post_rst_data", data, 8'h11);
    check_eq("post_rst_sof", sof, 1);
    repeat (2) step(0, '0, 1);

    // Back-to-back frames
    async_reset();
    cnt = 0;
    for (int i = 0; i < 36; i++) begin
      if (i < 2 * FRAME) step(1, DATA_W'(i), 1);
      else step(0, '0, 1);
      if (frame_done) cnt++;
      if (i >= 1 && i <= 2 * FRAME) check_eq("b2b_no_gap", valid, 1);
      if (i == FRAME + 1) begin
        check_eq("b2b_pix16", data, FRAME);
        check_eq("b2b_sof16", sof, 1);
      end
    end
    check_eq("b2b_done_cnt", cnt, 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 2) != 0);
    repeat (8) step(0, '0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
